// File: rtl/fft_frame_scheduler_if.sv
// fft_frame_scheduler_if: grant/request, module1 handshake and output framing signals of the scheduler
interface fft_frame_scheduler_if;
   logic       enable;
   logic [1:0] req;
   logic [1:0] gnt;
   logic       sel;
   logic       beat_rd;
   logic       m1_din_valid;
   logic       m1_valid_out;
   logic       out_frame_start;
   logic       out_frame_end;
   logic       out_ch;
   logic       busy;
   logic       err_orphan;
   modport master (
      output enable, req, m1_valid_out,
      input  gnt, sel, beat_rd, m1_din_valid, out_frame_start, out_frame_end, out_ch, busy, err_orphan
   );
   modport slave (
      input  enable, req, m1_valid_out,
      output gnt, sel, beat_rd, m1_din_valid, out_frame_start, out_frame_end, out_ch, busy, err_orphan
   );
endinterface

// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: round-robin whole-frame arbiter for the shared module1 front-end with in-flight channel tagging
module fft_frame_scheduler #(
   parameter int BEATS      = 32,
   parameter int TAG_DEPTH  = 4,
   parameter int GAP_CYCLES = 1
) (
   input logic clk,
   input logic rst,
   fft_frame_scheduler_if.slave bus
);
   localparam int CW = $clog2(BEATS);
   localparam int PW = $clog2(TAG_DEPTH);
   localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(TAG_DEPTH);
   typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;
   state_t state, nxt_state;
   logic [1:0] gnt, nxt_gnt;
   logic sel, nxt_sel, dv, nxt_dv, rr_last, nxt_rr, push, pop, ch, err;
   logic eligible, beat_ok, empty, full;
   logic [CW-1:0] in_cnt, nxt_in_cnt, out_cnt;
   logic [GW-1:0] gap_cnt, nxt_gap_cnt;
   logic [TAG_DEPTH-1:0] tags;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0] count;
   assign empty = count == '0;
   assign full = count == FULL_CNT;
   assign eligible = bus.enable & |bus.req & ~full;
   assign ch = &bus.req ? ~rr_last : bus.req[1];
   assign beat_ok = bus.m1_valid_out & ~empty;
   assign pop = beat_ok & (out_cnt == LAST);
   // Next-state and next registered outputs: grant in IDLE, gapless BEATS-beat stream, optional idle gap
   always_comb begin
      nxt_state = state;
      nxt_gnt = '0;
      nxt_sel = sel;
      nxt_dv = 1'b0;
      nxt_rr = rr_last;
      nxt_in_cnt = in_cnt;
      nxt_gap_cnt = gap_cnt;
      push = 1'b0;
      case (state)
         IDLE:
            if (eligible) begin
               nxt_state = STREAM;
               nxt_gnt = ch ? 2'b10 : 2'b01;
               nxt_sel = ch;
               nxt_rr = ch;
               nxt_dv = 1'b1;
               nxt_in_cnt = '0;
               push = 1'b1;
            end
         STREAM:
            if (in_cnt == LAST) begin
               nxt_state = GAP_CYCLES > 0 ? GAP : IDLE;
               nxt_gap_cnt = '0;
            end else begin
               nxt_dv = 1'b1;
               nxt_in_cnt = in_cnt + 1'b1;
            end
         GAP:
            if (gap_cnt == GAP_LAST) nxt_state = IDLE;
            else nxt_gap_cnt = gap_cnt + 1'b1;
         default: nxt_state = IDLE;
      endcase
   end
   // FSM state and registered outputs; rr_last starts at 1 so channel 0 wins the first tie
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         gnt <= '0;
         sel <= 1'b0;
         dv <= 1'b0;
         rr_last <= 1'b1;
         in_cnt <= '0;
         gap_cnt <= '0;
      end else begin
         state <= nxt_state;
         gnt <= nxt_gnt;
         sel <= nxt_sel;
         dv <= nxt_dv;
         rr_last <= nxt_rr;
         in_cnt <= nxt_in_cnt;
         gap_cnt <= nxt_gap_cnt;
      end
   // Channel-tag FIFO: written at each grant, advanced on the last output beat of each frame
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         tags <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (push) tags[wr_ptr] <= nxt_sel;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
   // Output beat position within a frame; beats arriving with nothing in flight are flagged, not counted
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         out_cnt <= '0;
         err <= 1'b0;
      end else begin
         if (beat_ok) out_cnt <= out_cnt == LAST ? '0 : out_cnt + 1'b1;
         if (bus.m1_valid_out & empty) err <= 1'b1;
      end
   assign bus.gnt = gnt;
   assign bus.sel = sel;
   assign bus.beat_rd = dv;
   assign bus.m1_din_valid = dv;
   assign bus.out_frame_start = beat_ok & (out_cnt == '0);
   assign bus.out_frame_end = pop;
   assign bus.out_ch = tags[rd_ptr];
   assign bus.busy = (state != IDLE) | ~empty;
   assign bus.err_orphan = err;
endmodule
